alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised multi-cycle successor to the processor's 32-bit combinational ALU.
- Keeps the existing single-cycle operations and 4-bit opcodes, and adds iterative multiply, divide and remainder.
- Adds a valid/ready handshake on both input and output, so the execute stage can stall on long operations.
- Results and status flags (Carry_Out, Overflow, Zero) are registered.

Parameters:
- WIDTH, 32, operand and result width (minimum 8).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and opcode present.
- in_ready  out  1  block can accept an operation.
- A_in  in  WIDTH  operand A.
- B_in  in  WIDTH  operand B.
- ALU_Sel  in  4  opcode.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer takes the result.
- ALU_Out  out  WIDTH  result.
- Carry_Out  out  1  carry/borrow flag.
- Overflow  out  1  signed overflow flag.
- Zero  out  1  ALU_Out == 0.
- Illegal  out  1  opcode was undefined.

Behaviour:
- Reset (async, any state, including mid-iteration): state IDLE; ALU_Out=0; all flags 0; out_valid=0; in_ready=1 once reset deasserts. An in-flight operation is discarded.
- States:
  - IDLE: in_ready=1. A transfer occurs when in_valid && in_ready.
  - BUSY: iterating. in_ready=0.
  - DONE: out_valid=1 and outputs held stable. Moves to IDLE when out_ready=1. in_ready=0, so there is no same-cycle reissue.
- Single-cycle opcodes (transfer in cycle N, DONE with out_valid in N+1):
  - 0000 AND, 0001 OR, 1100 NOR, 0100 XOR.
  - 0010 ADD: {Carry_Out,ALU_Out}=A+B (WIDTH+1 bits). Overflow=1 iff A and B have the same sign and the result sign differs.
  - 0110 SUB: {Carry_Out,ALU_Out}=A−B. Overflow=1 iff A and B have different signs and the result sign differs from A.
  - 0111 SLT signed, 0011 SLTU unsigned: ALU_Out = 1 or 0.
  - 1111 EQ: ALU_Out=(A==B).
  - Carry_Out and Overflow are 0 for every opcode other than ADD and SUB.
- Multi-cycle opcodes (enter BUSY for exactly WIDTH cycles, then DONE; out_valid first high in cycle N+WIDTH+1):
  - 1000 MUL: low WIDTH bits of A*B.
  - 1001 MULH: high WIDTH bits, signed×signed.
  - 1010 MULHU: high WIDTH bits, unsigned×unsigned.
  - 1011 DIV signed, 1101 DIVU unsigned, 1110 REM signed, 0101 REMU unsigned.
- Multiply method: operands converted to magnitudes for signed ops; shift-add one bit per cycle into a 2*WIDTH product; sign applied on the final cycle.
- Divide method: restoring division, one quotient bit per cycle. Signed ops divide magnitudes. Quotient sign = sign(A)^sign(B); remainder sign = sign(A).
- Divide by zero (B==0), decided when the operation is accepted, still takes WIDTH cycles:
  - DIV/DIVU: ALU_Out = all ones.
  - REM/REMU: ALU_Out = A.
  - Overflow = 0.
- Signed overflow (A=MIN, B=−1, DIV/REM only):
  - DIV: ALU_Out = MIN, Overflow = 1.
  - REM: ALU_Out = 0, Overflow = 1.
- Undefined opcodes (1000–1111 unlisted codes, none currently): treated as single-cycle; ALU_Out=0, Zero=1, Illegal=1.
- Zero is computed from the final registered ALU_Out for every opcode.
- Operands and opcode are captured at transfer; input changes during BUSY or DONE are ignored.
- in_valid asserted while in_ready=0 has no effect; the upstream must hold its request.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (OP_AND … OP_REMU);
  - the state encoding (S_IDLE, S_BUSY, S_DONE);
  - a function is_multicycle(op).
- Sub-module alu_muldiv_seq: shared iterative datapath.
  - Ports: start, is_div, signed_a, signed_b, want_hi_or_rem, A, B.
  - Outputs: done, result, ovf.
  - The parent FSM keeps the single-cycle ops, the flags and the handshake.

Test Plan (WIDTH=32):
- ADD A=0x7FFFFFFF, B=1, out_ready=1 -> out_valid one cycle after transfer; ALU_Out=0x80000000, Overflow=1, Carry_Out=0, Zero=0. Then SUB A=5, B=5 -> ALU_Out=0, Zero=1, Carry_Out=0.
- MULH A=0xFFFFFFFE (−2), B=3 -> out_valid exactly 33 cycles after transfer; ALU_Out=0xFFFFFFFF. MUL with the same operands -> 0xFFFFFFFA.
- DIV A=−7, B=2 -> ALU_Out=0xFFFFFFFD (−3). REM with the same operands -> 0xFFFFFFFF (−1). DIVU A=7, B=0 -> 0xFFFFFFFF. REMU A=7, B=0 -> 7.
- DIV A=0x80000000, B=0xFFFFFFFF -> ALU_Out=0x80000000, Overflow=1. REM with the same operands -> 0, Zero=1.
- Backpressure: SLT A=−1, B=1 with out_ready=0 for 5 cycles -> out_valid and ALU_Out=1 held stable, in_ready=0, and a new in_valid is ignored. After out_ready pulses: IDLE, in_ready=1.
- Reset asserted asynchronously 10 cycles into a DIVU -> outputs 0 immediately. After release, in_ready=1 and the next ADD 2+3 returns 5 normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and opcode classification helpers for the
// multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLTU  = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_REMU  = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_MULH  = 4'b1001;
    localparam logic [3:0] OP_MULHU = 4'b1010;
    localparam logic [3:0] OP_DIV   = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1101;
    localparam logic [3:0] OP_REM   = 4'b1110;
    localparam logic [3:0] OP_EQ    = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_multicycle(input logic [3:0] op);
        case (op)
            OP_MUL, OP_MULH, OP_MULHU,
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    function automatic logic op_is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic op_is_signed(input logic [3:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_hi_or_rem(input logic [3:0] op);
        return (op == OP_MULH) || (op == OP_MULHU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative shift-add multiplier / restoring divider sharing one register set.
// The first iteration runs on the start edge, so done rises WIDTH-1 cycles later.
module alu_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_is_div,
    input  logic             i_signed_a,
    input  logic             i_signed_b,
    input  logic             i_want_hi_or_rem,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_ovf
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic               r_busy;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;
    logic               r_hi_rem;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_dz;
    logic               r_ovf;
    logic [WIDTH-1:0]   r_a_orig;
    // Multiply: product / shifted multiplicand / multiplier.
    // Divide: partial remainder (low half) / divisor (low half) / dividend->quotient.
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_opa;
    logic [WIDTH-1:0]   r_opb;

    logic               w_sa, w_sb;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic               w_cur_div;
    logic [2*WIDTH-1:0] w_cur_acc, w_cur_opa, w_nxt_acc, w_nxt_opa;
    logic [WIDTH-1:0]   w_cur_opb, w_nxt_opb;
    logic [WIDTH:0]     w_trial;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo, w_rem;

    assign w_sa    = i_signed_a & i_a[WIDTH-1];
    assign w_sb    = i_signed_b & i_b[WIDTH-1];
    assign w_mag_a = w_sa ? (~i_a + 1'b1) : i_a;
    assign w_mag_b = w_sb ? (~i_b + 1'b1) : i_b;

    always_comb begin
        w_cur_div = r_is_div;
        w_cur_acc = r_acc;
        w_cur_opa = r_opa;
        w_cur_opb = r_opb;
        if (i_start) begin
            w_cur_div = i_is_div;
            w_cur_acc = '0;
            if (i_is_div) begin
                w_cur_opa = {{WIDTH{1'b0}}, w_mag_b};
                w_cur_opb = w_mag_a;
            end else begin
                w_cur_opa = {{WIDTH{1'b0}}, w_mag_a};
                w_cur_opb = w_mag_b;
            end
        end
    end

    always_comb begin
        w_trial   = {w_cur_acc[WIDTH-1:0], w_cur_opb[WIDTH-1]};
        w_ge      = (w_trial >= {1'b0, w_cur_opa[WIDTH-1:0]});
        w_nxt_acc = w_cur_acc;
        w_nxt_opa = w_cur_opa;
        w_nxt_opb = w_cur_opb;
        if (w_cur_div) begin
            if (w_ge) begin
                w_nxt_acc = {{WIDTH{1'b0}}, w_trial[WIDTH-1:0] - w_cur_opa[WIDTH-1:0]};
            end else begin
                w_nxt_acc = {{WIDTH{1'b0}}, w_trial[WIDTH-1:0]};
            end
            w_nxt_opb = {w_cur_opb[WIDTH-2:0], w_ge};
        end else begin
            w_nxt_acc = w_cur_acc + (w_cur_opb[0] ? w_cur_opa : '0);
            w_nxt_opa = w_cur_opa << 1;
            w_nxt_opb = w_cur_opb >> 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_hi_rem  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
            r_ovf     <= 1'b0;
            r_a_orig  <= '0;
            r_acc     <= '0;
            r_opa     <= '0;
            r_opb     <= '0;
        end else if (i_start) begin
            r_busy    <= 1'b1;
            r_cnt     <= CNT_W'(WIDTH - 1);
            r_is_div  <= i_is_div;
            r_hi_rem  <= i_want_hi_or_rem;
            r_neg_res <= w_sa ^ w_sb;
            r_neg_rem <= w_sa;
            r_dz      <= i_is_div && (i_b == '0);
            r_ovf     <= i_is_div && i_signed_a && i_signed_b &&
                         (i_a == {1'b1, {(WIDTH-1){1'b0}}}) && (i_b == '1);
            r_a_orig  <= i_a;
            r_acc     <= w_nxt_acc;
            r_opa     <= w_nxt_opa;
            r_opb     <= w_nxt_opb;
        end else if (r_busy) begin
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
                r_acc <= w_nxt_acc;
                r_opa <= w_nxt_opa;
                r_opb <= w_nxt_opb;
            end
        end
    end

    // Signs are applied to the magnitude results only on the way out.
    assign w_prod = r_neg_res ? (~r_acc + 1'b1) : r_acc;
    assign w_quo  = r_neg_res ? (~r_opb + 1'b1) : r_opb;
    assign w_rem  = r_neg_rem ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];

    always_comb begin
        o_result = '0;
        if (r_is_div) begin
            if (r_dz) begin
                o_result = r_hi_rem ? r_a_orig : '1;
            end else begin
                o_result = r_hi_rem ? w_rem : w_quo;
            end
        end else begin
            o_result = r_hi_rem ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];
        end
    end

    assign o_done = r_busy && (r_cnt == '0);
    assign o_ovf  = r_ovf;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative mul/div with
// valid/ready handshakes and registered result and flags.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    input  logic [3:0]       ALU_Sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             Carry_Out,
    output logic             Overflow,
    output logic             Zero,
    output logic             Illegal,
    output state_t           dbg_state
);

    // Handshake: an operation transfers on a clock edge where in_valid && in_ready;
    // a result is consumed on a clock edge where out_valid && out_ready.
    state_t           r_state, w_next_state;
    logic [WIDTH-1:0] r_out;
    logic             r_carry, r_ovf, r_zero, r_illegal;

    logic             w_xfer, w_multi, w_md_start, w_md_done, w_md_ovf;
    logic [WIDTH-1:0] w_md_result;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH:0]   w_sum;
    logic             w_carry, w_ovf, w_illegal;

    assign w_xfer     = in_valid && in_ready;
    assign w_multi    = is_multicycle(ALU_Sel);
    assign w_md_start = w_xfer && w_multi;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_xfer) w_next_state = w_multi ? S_BUSY : S_DONE;
            S_BUSY:  if (w_md_done) w_next_state = S_DONE;
            S_DONE:  if (out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        dbg_state = r_state;
    end

    always_comb begin
        w_res     = '0;
        w_sum     = '0;
        w_carry   = 1'b0;
        w_ovf     = 1'b0;
        w_illegal = 1'b0;
        case (ALU_Sel)
            OP_AND:  w_res = A_in & B_in;
            OP_OR:   w_res = A_in | B_in;
            OP_NOR:  w_res = ~(A_in | B_in);
            OP_XOR:  w_res = A_in ^ B_in;
            OP_ADD: begin
                w_sum   = {1'b0, A_in} + {1'b0, B_in};
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (A_in[WIDTH-1] == B_in[WIDTH-1]) && (w_res[WIDTH-1] != A_in[WIDTH-1]);
            end
            OP_SUB: begin
                w_sum   = {1'b0, A_in} - {1'b0, B_in};
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (A_in[WIDTH-1] != B_in[WIDTH-1]) && (w_res[WIDTH-1] != A_in[WIDTH-1]);
            end
            OP_SLT:  w_res = WIDTH'($signed(A_in) < $signed(B_in));
            OP_SLTU: w_res = WIDTH'(A_in < B_in);
            OP_EQ:   w_res = WIDTH'(A_in == B_in);
            OP_MUL, OP_MULH, OP_MULHU,
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: w_res = '0;
            default: w_illegal = 1'b1;
        endcase
    end

    alu_muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
        .clk              (clk),
        .rst              (reset),
        .i_start          (w_md_start),
        .i_is_div         (op_is_div(ALU_Sel)),
        .i_signed_a       (op_is_signed(ALU_Sel)),
        .i_signed_b       (op_is_signed(ALU_Sel)),
        .i_want_hi_or_rem (op_hi_or_rem(ALU_Sel)),
        .i_a              (A_in),
        .i_b              (B_in),
        .o_done           (w_md_done),
        .o_result         (w_md_result),
        .o_ovf            (w_md_ovf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out     <= '0;
            r_carry   <= 1'b0;
            r_ovf     <= 1'b0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_xfer && !w_multi) begin
            r_out     <= w_res;
            r_carry   <= w_carry;
            r_ovf     <= w_ovf;
            r_zero    <= (w_res == '0);
            r_illegal <= w_illegal;
        end else if (r_state == S_BUSY && w_md_done) begin
            r_out     <= w_md_result;
            r_carry   <= 1'b0;
            r_ovf     <= w_md_ovf;
            r_zero    <= (w_md_result == '0);
            r_illegal <= 1'b0;
        end
    end

    assign ALU_Out   = r_out;
    assign Carry_Out = r_carry;
    assign Overflow  = r_ovf;
    assign Zero      = r_zero;
    assign Illegal   = r_illegal;

endmodule

// File: tb/tb_alu_mc.sv
// Directed, table-driven bench for alu_mc with hand-written backpressure and
// mid-operation reset sequences.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A_in, B_in;
    logic [3:0]   ALU_Sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] ALU_Out;
    logic         Carry_Out, Overflow, Zero, Illegal;
    state_t       dbg_state;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_out;
        logic         exp_c;
        logic         exp_v;
        logic         exp_z;
        logic [7:0]   exp_lat;
    } vec_t;

    vec_t vecs[$];

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A_in      (A_in),
        .B_in      (B_in),
        .ALU_Sel   (ALU_Sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALU_Out   (ALU_Out),
        .Carry_Out (Carry_Out),
        .Overflow  (Overflow),
        .Zero      (Zero),
        .Illegal   (Illegal),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic void add(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] e, input logic c, input logic v, input logic z,
                                input int lat);
        vec_t t;
        t.op = op; t.a = a; t.b = b; t.exp_out = e;
        t.exp_c = c; t.exp_v = v; t.exp_z = z; t.exp_lat = 8'(lat);
        vecs.push_back(t);
    endfunction

    // Called #1 after a rising edge with in_ready high; returns #1 after the transfer edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        ALU_Sel  = op;
        A_in     = a;
        B_in     = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts cycles from the transfer cycle; the first sample after the transfer edge is 1.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        issue(v.op, v.a, v.b);
        wait_out(lat);
        check($sformatf("v%0d latency", idx), W'(lat), W'(v.exp_lat));
        check($sformatf("v%0d ALU_Out", idx), ALU_Out, v.exp_out);
        check($sformatf("v%0d Carry_Out", idx), W'(Carry_Out), W'(v.exp_c));
        check($sformatf("v%0d Overflow", idx), W'(Overflow), W'(v.exp_v));
        check($sformatf("v%0d Zero", idx), W'(Zero), W'(v.exp_z));
        check($sformatf("v%0d Illegal", idx), W'(Illegal), '0);
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A_in      = '0;
        B_in      = '0;
        ALU_Sel   = OP_AND;

        //      op        A             B             expected      C     V     Z     lat
        add(OP_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1);
        add(OP_SUB,   32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b0, 1'b1, 1);
        add(OP_SUB,   32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 1);
        add(OP_ADD,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1);
        add(OP_AND,   32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1);
        add(OP_OR,    32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 1'b0, 1'b0, 1);
        add(OP_NOR,   32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1);
        add(OP_XOR,   32'hA5A5A5A5, 32'hFFFFFFFF, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b0, 1);
        add(OP_SLTU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b1, 1);
        add(OP_EQ,    32'h00001234, 32'h00001234, 32'h00000001, 1'b0, 1'b0, 1'b0, 1);
        add(OP_MULH,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 33);
        add(OP_MUL,   32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 1'b0, 1'b0, 1'b0, 33);
        add(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 33);
        add(OP_MULH,  32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1'b0, 1'b0, 33);
        add(OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0, 33);
        add(OP_REM,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 33);
        add(OP_DIVU,  32'h00000007, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 33);
        add(OP_REMU,  32'h00000007, 32'h00000000, 32'h00000007, 1'b0, 1'b0, 1'b0, 33);
        add(OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 33);
        add(OP_REM,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1'b0, 1'b0, 1'b0, 33);
        add(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, 1'b0, 33);
        add(OP_REM,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b1, 33);
        add(OP_DIVU,  32'h00000064, 32'h00000007, 32'h0000000E, 1'b0, 1'b0, 1'b0, 33);
        add(OP_REMU,  32'h00000064, 32'h00000007, 32'h00000002, 1'b0, 1'b0, 1'b0, 33);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("reset in_ready", W'(in_ready), W'(1));
        check("reset out_valid", W'(out_valid), '0);
        check("reset ALU_Out", ALU_Out, '0);
        check("reset flags", W'({Carry_Out, Overflow, Zero, Illegal}), '0);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Backpressure: result held while out_ready is low, new requests ignored
        out_ready = 1'b0;
        issue(OP_SLT, 32'hFFFFFFFF, 32'h00000001);
        wait_out(lat);
        check("bp latency", W'(lat), W'(1));
        for (int i = 0; i < 5; i++) begin
            ALU_Sel  = OP_ADD;
            A_in     = W'(i + 10);
            B_in     = W'(i);
            in_valid = 1'b1;
            @(posedge clk); #1;
            check($sformatf("bp%0d out_valid", i), W'(out_valid), W'(1));
            check($sformatf("bp%0d ALU_Out", i), ALU_Out, W'(1));
            check($sformatf("bp%0d in_ready", i), W'(in_ready), '0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp release out_valid", W'(out_valid), '0);
        check("bp release in_ready", W'(in_ready), W'(1));
        check("bp release state", W'(dbg_state), W'(S_IDLE));
        check("bp release ALU_Out", ALU_Out, W'(1));

        // Load every flag with 1 so the reset clear is visible
        run_vec('{OP_ADD, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b1, 8'd1}, 100);

        // Asynchronous reset in the middle of a DIVU
        issue(OP_DIVU, 32'h000003E8, 32'h00000003);
        repeat (9) @(posedge clk);
        #2;
        check("pre-reset state", W'(dbg_state), W'(S_BUSY));
        reset = 1'b1;
        #1;
        check("async reset out_valid", W'(out_valid), '0);
        check("async reset ALU_Out", ALU_Out, '0);
        check("async reset flags", W'({Carry_Out, Overflow, Zero, Illegal}), '0);
        check("async reset state", W'(dbg_state), W'(S_IDLE));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("post-reset in_ready", W'(in_ready), W'(1));
        run_vec('{OP_ADD, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b0, 1'b0, 8'd1}, 101);
        repeat (40) @(posedge clk);
        #1;
        check("no stale result", W'(out_valid), '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
